// File: rtl/vend_pkg.sv
// vend_pkg
// Shared types and constants for the vending machine datapath: the payout
// FSM state encoding and the coin values in quarter units. The change
// dispenser and the HEX display decoder both import this package.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } disp_state_t;

  localparam int QUARTER_UNITS = 1;
  localparam int HALF_UNITS    = 2;
  localparam int MAX_CHANGE    = 7;

endpackage

// File: rtl/coin_gap_timer.sv
// coin_gap_timer
// Loadable down-counter that times the idle gap after each coin pulse.
// It stops at zero.
// Ports:
//   CLK      clock
//   RES      asynchronous active-low reset (clears the count)
//   load     load load_val this edge (takes priority over dec)
//   load_val value loaded on load
//   dec      decrement this edge, if not already zero
//   zero     count currently reads zero
module coin_gap_timer #(
  parameter int CNT_W = 2
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser
// Sequential change-payout engine. It accepts a change amount in quarter
// units. It then pays the amount out one coin at a time to the hopper,
// choosing a half dollar whenever at least two quarters are still owed.
// Each coin pulse is followed by a fixed idle gap.
// Ports:
//   CLK            clock
//   RES            asynchronous active-low reset
//   dispense_req   start a payout (only looked at while idle)
//   change_amt     amount owed, in quarters, sampled with dispense_req
//   hopper_ready   hopper accepts a coin command this cycle
//   quarter_out    one-cycle pulse: eject a quarter
//   halfDollar_out one-cycle pulse: eject a half dollar
//   busy           payout in progress (any state but IDLE)
//   done           one-cycle pulse at the end of a payout
//   remaining      quarters still owed
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W      = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             dispense_req,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             hopper_ready,
  output logic             quarter_out,
  output logic             halfDollar_out,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] remaining
);

  // With GAP_CYCLES == 1 the counter only ever holds 0, but it still needs
  // one bit to exist.
  localparam int               CNT_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  disp_state_t      state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic             quarter_q, quarter_d;
  logic             half_q, half_d;
  logic             take_coin;
  logic             use_half;
  logic             gap_zero;

  // A coin is committed on the edge that leaves ISSUE with the hopper ready.
  assign take_coin = (state_q == ISSUE) && hopper_ready;
  assign use_half  = (remaining_q >= AMT_W'(HALF_UNITS));

  coin_gap_timer #(
    .CNT_W(CNT_W)
  ) u_gap_timer (
    .CLK     (CLK),
    .RES     (RES),
    .load    (take_coin),
    .load_val(GAP_LOAD),
    .dec     (state_q == GAP),
    .zero    (gap_zero)
  );

  // State register.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dispense_req) begin
          state_d = (change_amt != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (hopper_ready) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_zero) begin
          // remaining_q already reflects the coin just issued.
          state_d = (remaining_q != '0) ? ISSUE : DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Remaining amount and registered coin pulses. The pulses are high only
  // in the cycle after take_coin, which is always the first GAP cycle.
  always_comb begin
    remaining_d = remaining_q;
    quarter_d   = 1'b0;
    half_d      = 1'b0;
    if ((state_q == IDLE) && dispense_req && (change_amt != '0)) begin
      remaining_d = change_amt;
    end else if (take_coin) begin
      if (use_half) begin
        half_d      = 1'b1;
        remaining_d = remaining_q - AMT_W'(HALF_UNITS);
      end else begin
        quarter_d   = 1'b1;
        remaining_d = remaining_q - AMT_W'(QUARTER_UNITS);
      end
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      remaining_q <= '0;
      quarter_q   <= 1'b0;
      half_q      <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      quarter_q   <= quarter_d;
      half_q      <= half_d;
    end
  end

  // Output logic.
  always_comb begin
    busy           = (state_q != IDLE);
    done           = (state_q == DONE);
    quarter_out    = quarter_q;
    halfDollar_out = half_q;
    remaining      = remaining_q;
  end

endmodule
